// File: rtl/vend_coin_tx.sv
// vend_coin_tx: greedy coin transmitter feeding a vend FSM, with a configurable idle gap between coins.
module vend_coin_tx #(
   parameter int GAP = 1
) (
   input  logic       Clk,
   input  logic       Reset,
   input  logic       Start,
   input  logic [3:0] Amount,
   output logic [1:0] D_out,
   output logic       Busy,
   output logic       Done,
   output logic [3:0] Coin_cnt
);
   typedef enum logic [1:0] {S_IDLE, S_COIN, S_GAP, S_DONE} state_t;
   localparam logic [2:0] GAP_LAST = 3'(GAP - 1);
   localparam logic       GAP_ZERO = (GAP == 0);
   state_t     r_state, w_next;
   logic [3:0] r_remain, r_cnt, w_dec, w_remain_nxt;
   logic [2:0] r_gap_cnt;
   // COIN is only entered with remain>=1, so this subtraction cannot underflow
   assign w_dec        = (r_remain >= 4'd2) ? 4'd2 : {3'b000, |r_remain};
   assign w_remain_nxt = r_remain - w_dec;
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) r_state <= S_IDLE;
      else       r_state <= w_next;
   end
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         r_remain  <= 4'd0;
         r_cnt     <= 4'd0;
         r_gap_cnt <= 3'd0;
      end else if (r_state == S_IDLE && Start) begin
         r_remain <= Amount;
         r_cnt    <= 4'd0;
      end else if (r_state == S_COIN) begin
         r_remain  <= w_remain_nxt;
         r_cnt     <= r_cnt + 4'd1;
         r_gap_cnt <= 3'd0;
      end else if (r_state == S_GAP) begin
         r_gap_cnt <= r_gap_cnt + 3'd1;
      end
   end
   always_comb begin
      w_next = r_state;
      unique case (r_state)
         S_IDLE: w_next = !Start ? S_IDLE : (Amount != 4'd0) ? S_COIN : S_DONE;
         S_COIN: w_next = (w_remain_nxt == 4'd0) ? S_DONE : GAP_ZERO ? S_COIN : S_GAP;
         S_GAP:  w_next = (r_gap_cnt == GAP_LAST) ? S_COIN : S_GAP;
         S_DONE: w_next = S_IDLE;
      endcase
   end
   always_comb begin
      D_out    = (r_state != S_COIN) ? 2'b00 : (r_remain >= 4'd2) ? 2'b10 : (r_remain == 4'd1) ? 2'b01 : 2'b00;
      Busy     = (r_state != S_IDLE);
      Done     = (r_state == S_DONE);
      Coin_cnt = r_cnt;
   end
endmodule

// File: tb/tb_vend_coin_tx.sv
// tb_vend_coin_tx: directed vector table plus hand sequences over GAP=0/1/2 instances sharing stimulus.
module tb_vend_coin_tx;
   logic       Clk = 1'b0, Reset = 1'b0, Start = 1'b0;
   logic [3:0] Amount = 4'd0;
   logic [1:0] d0, d1, d2;
   logic       b0, b1, b2, dn0, dn1, dn2;
   logic [3:0] c0, c1, c2;
   int n_chk = 0, n_fail = 0;

   always #5 Clk = ~Clk;

   vend_coin_tx #(.GAP(0)) u0 (.Clk(Clk), .Reset(Reset), .Start(Start), .Amount(Amount), .D_out(d0), .Busy(b0), .Done(dn0), .Coin_cnt(c0));
   vend_coin_tx #(.GAP(1)) u1 (.Clk(Clk), .Reset(Reset), .Start(Start), .Amount(Amount), .D_out(d1), .Busy(b1), .Done(dn1), .Coin_cnt(c1));
   vend_coin_tx #(.GAP(2)) u2 (.Clk(Clk), .Reset(Reset), .Start(Start), .Amount(Amount), .D_out(d2), .Busy(b2), .Done(dn2), .Coin_cnt(c2));

   typedef struct {
      logic [3:0] amt;
      int         sel;
      string      pat;
      logic [3:0] cnt;
      string      name;
   } vec_t;
   vec_t vt[10];

   function automatic logic [1:0] d_of(int s);    return s == 0 ? d0  : s == 1 ? d1  : d2;  endfunction
   function automatic logic       busy_of(int s); return s == 0 ? b0  : s == 1 ? b1  : b2;  endfunction
   function automatic logic       done_of(int s); return s == 0 ? dn0 : s == 1 ? dn1 : dn2; endfunction
   function automatic logic [3:0] cnt_of(int s);  return s == 0 ? c0  : s == 1 ? c1  : c2;  endfunction
   function automatic logic [1:0] sym(byte ch);   return ch == "F" ? 2'b10 : ch == "H" ? 2'b01 : 2'b00; endfunction

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic check_all_zero(input string tag);
      for (int s = 0; s < 3; s++) begin
         check($sformatf("%s d_out u%0d", tag, s), 32'(d_of(s)), 0);
         check($sformatf("%s busy u%0d", tag, s), 32'(busy_of(s)), 0);
         check($sformatf("%s done u%0d", tag, s), 32'(done_of(s)), 0);
         check($sformatf("%s cnt u%0d", tag, s), 32'(cnt_of(s)), 0);
      end
   endtask

   // Start accepted at the next edge; coins from the following cycle, Done right after the last one.
   task automatic run_vec(input vec_t v);
      Start = 1'b1;
      Amount = v.amt;
      tick();
      Start = 1'b0;
      Amount = ~v.amt;
      for (int k = 0; k < v.pat.len(); k++) begin
         check($sformatf("%s d_out[%0d]", v.name, k), 32'(d_of(v.sel)), 32'(sym(v.pat[k])));
         check($sformatf("%s busy[%0d]", v.name, k), 32'(busy_of(v.sel)), 1);
         check($sformatf("%s done[%0d]", v.name, k), 32'(done_of(v.sel)), 0);
         tick();
      end
      check({v.name, " done"}, 32'(done_of(v.sel)), 1);
      check({v.name, " done busy"}, 32'(busy_of(v.sel)), 1);
      check({v.name, " done d_out"}, 32'(d_of(v.sel)), 0);
      check({v.name, " coin_cnt"}, 32'(cnt_of(v.sel)), 32'(v.cnt));
      tick();
      check({v.name, " idle busy"}, 32'(busy_of(v.sel)), 0);
      check({v.name, " idle done"}, 32'(done_of(v.sel)), 0);
      repeat (30) tick();
      check({v.name, " cnt hold"}, 32'(cnt_of(v.sel)), 32'(v.cnt));
   endtask

   initial begin
      vt[0] = '{4'd5,  1, "F-F-H",                  4'd3, "amt5_gap1"};
      vt[1] = '{4'd4,  0, "FF",                     4'd2, "amt4_gap0"};
      vt[2] = '{4'd0,  1, "",                       4'd0, "amt0_gap1"};
      vt[3] = '{4'd15, 2, "F--F--F--F--F--F--F--H", 4'd8, "amt15_gap2"};
      vt[4] = '{4'd5,  0, "FFH",                    4'd3, "amt5_gap0"};
      vt[5] = '{4'd1,  0, "H",                      4'd1, "amt1_gap0"};
      vt[6] = '{4'd2,  2, "F",                      4'd1, "amt2_gap2"};
      vt[7] = '{4'd7,  1, "F-F-F-H",                4'd4, "amt7_gap1"};
      vt[8] = '{4'd15, 0, "FFFFFFFH",               4'd8, "amt15_gap0"};
      vt[9] = '{4'd3,  2, "F--H",                   4'd2, "amt3_gap2"};

      #1 Reset = 1'b1;
      #1 check_all_zero("reset");
      tick();
      tick();
      Reset = 1'b0;
      tick();
      check_all_zero("post_reset");

      foreach (vt[i]) run_vec(vt[i]);

      // Start held high: Amount change mid-flight ignored, restart on first IDLE cycle after DONE
      Start = 1'b1;
      Amount = 4'd2;
      tick();
      Amount = 4'd3;
      check("hold d_out t1", 32'(d1), 2);
      tick();
      check("hold done t2", 32'(dn1), 1);
      check("hold cnt t2", 32'(c1), 1);
      tick();
      check("hold idle busy t3", 32'(b1), 0);
      tick();
      Start = 1'b0;
      check("hold2 d_out t4", 32'(d1), 2);
      check("hold2 cnt t4", 32'(c1), 0);
      tick();
      check("hold2 d_out t5", 32'(d1), 0);
      tick();
      check("hold2 d_out t6", 32'(d1), 1);
      tick();
      check("hold2 done t7", 32'(dn1), 1);
      check("hold2 cnt t7", 32'(c1), 2);
      repeat (20) tick();

      // Start pulses while busy are ignored
      Start = 1'b1;
      Amount = 4'd4;
      tick();
      Amount = 4'd9;
      check("busy_ign d_out t1", 32'(d1), 2);
      tick();
      check("busy_ign d_out t2", 32'(d1), 0);
      tick();
      Start = 1'b0;
      check("busy_ign d_out t3", 32'(d1), 2);
      tick();
      check("busy_ign done t4", 32'(dn1), 1);
      check("busy_ign cnt t4", 32'(c1), 2);
      tick();
      check("busy_ign idle t5", 32'(b1), 0);
      repeat (20) tick();

      // Reset after the second coin of Amount=6 aborts without Done
      Start = 1'b1;
      Amount = 4'd6;
      tick();
      Start = 1'b0;
      check("abort d_out t1", 32'(d1), 2);
      tick();
      check("abort d_out t2", 32'(d1), 0);
      tick();
      check("abort d_out t3", 32'(d1), 2);
      Reset = 1'b1;
      #1 check_all_zero("abort");
      tick();
      Reset = 1'b0;
      for (int k = 0; k < 8; k++) begin
         tick();
         check($sformatf("abort quiet d_out[%0d]", k), 32'(d1), 0);
         check($sformatf("abort quiet done[%0d]", k), 32'(dn1), 0);
         check($sformatf("abort quiet busy[%0d]", k), 32'(b1), 0);
      end
      run_vec('{4'd1, 1, "H", 4'd1, "after_abort_amt1"});

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/vend_coin_tx.md
VEND_COIN_TX -- requirements
Module: vend_coin_tx

Interface
REQ-001 Parameter GAP, default 1, number of idle cycles (D_out=2'b00) inserted between consecutive coins; legal range 0..7.
REQ-002 Clk  input  1  single clock; all state updates on its rising edge.
REQ-003 Reset  input  1  asynchronous, active-high reset.
REQ-004 Start  input  1  request to transmit an amount; sampled only in IDLE.
REQ-005 Amount  input  4  amount to transmit, in half-unit (0.5) steps, 0..15.
REQ-006 D_out  output  2  coin code driven toward a vend FSM D_in: 2'b00 none, 2'b01 half coin (0.5), 2'b10 full coin (1.0); 2'b11 never driven.
REQ-007 Busy  output  1  high whenever the FSM is not in IDLE.
REQ-008 Done  output  1  one-cycle pulse marking the end of a transmission.
REQ-009 Coin_cnt  output  4  number of coins emitted in the current or last transmission.

Function
REQ-010 FSM states: IDLE, COIN, GAP, DONE; all outputs registered or decoded from registered state, with no combinational path from inputs to outputs.
REQ-011 IDLE with Start=1 at edge t: Amount latched into a 4-bit remain register and Coin_cnt cleared to 0; the next state is COIN if Amount!=0, otherwise DONE.
REQ-012 IDLE with Start=0: state, remain and Coin_cnt hold, and D_out=2'b00.
REQ-013 COIN lasts exactly one cycle and uses greedy selection.
  - remain>=2: D_out=2'b10 and remain decreases by 2.
  - remain==1: D_out=2'b01 and remain decreases by 1.
  - Coin_cnt increments by 1 in both cases.
REQ-014 Exit from COIN:
  - New remain==0: go to DONE.
  - Otherwise with GAP==0: stay in COIN, giving back-to-back coins.
  - Otherwise: go to GAP.
REQ-015 GAP lasts exactly GAP cycles with D_out=2'b00, then returns to COIN; a 3-bit gap counter is cleared on GAP entry.
REQ-016 DONE lasts one cycle with Done=1, Busy=1 and D_out=2'b00, then goes to IDLE; Done is 0 in every other state.
REQ-017 Latency: the first coin appears on D_out in the cycle after Start is accepted; Done appears in the cycle after the last coin.
REQ-018 Start and Amount are ignored while Busy=1; changing Amount during a transmission does not affect it.
REQ-019 Start held high continuously starts a new transmission on the first IDLE cycle after DONE, so no two transmissions overlap.
REQ-020 Coin count per transmission is Amount/2 (integer) full coins plus Amount%2 half coins; the half coin, if any, is always last.
REQ-021 Coin_cnt holds its final value after DONE until the next accepted Start; remain never underflows.

Reset
REQ-022 When Reset=1, regardless of Clk, all of the following apply: state=IDLE, D_out=2'b00, Busy=0, Done=0, Coin_cnt=0, remain=0, gap counter=0.
REQ-023 Reset asserted mid-transmission aborts it immediately; no Done pulse is produced and no further coins are emitted after release.
REQ-024 After Reset deasserts, the first accepted Start behaves exactly as from power-up.

Verification
REQ-025 GAP=1, Start with Amount=5 accepted at edge t -> D_out per cycle t+1..t+5 = 10,00,10,00,01; Done=1 at t+6; Busy=0 at t+7; Coin_cnt=3.
REQ-026 GAP=0, Amount=4 -> D_out = 10,10 back-to-back; Done on the next cycle; Coin_cnt=2.
REQ-027 Amount=0 -> no coin emitted; Done=1 in the cycle after Start; Coin_cnt=0.
REQ-028 Amount=15 with GAP=2 -> seven 10 coins then one 01, each separated by exactly two 00 cycles; Coin_cnt=8.
REQ-029 Start held high and Amount changed to 3 mid-transmission of Amount=2 -> the first transmission emits a single 10; the next transmission starts the cycle after its DONE and emits 10 then 01.
REQ-030 Reset pulsed after the second coin of Amount=6 -> outputs zero immediately with no Done; a later Start with Amount=1 emits a single 01 and Coin_cnt=1.
